// File: rtl/engine_m_axi_stream_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : engine_m_axi_stream_alu_pkg
//  Description : Shared types for the lane-parallel stream ALU: per-lane
//                operation select and the run-control FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package engine_m_axi_stream_alu_pkg;

    // Per-lane operation select; encoding matches the ctrl_mode port.
    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_MAX  = 3'd5,
        ALU_MIN  = 3'd6,
        ALU_PASS = 3'd7
    } alu_mode_t;

    // Run-control FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } alu_state_t;

endpackage : engine_m_axi_stream_alu_pkg
`default_nettype wire

// File: rtl/engine_m_axi_stream_alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : engine_m_axi_stream_alu_if
//  Description : AXI4-Stream bundle (tvalid/tready/tdata/tkeep/tlast).
//                master modport drives the beat, slave modport drives tready.
//  Parameters  : DATA_WIDTH - tdata width in bits (tkeep is DATA_WIDTH/8)
//  Revision    : 1.0 - initial release
// ============================================================================
interface engine_m_axi_stream_alu_if #(
    parameter int DATA_WIDTH = 512
) ();

    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;

    modport master (
        output tvalid, tdata, tkeep, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast,
        output tready
    );

endinterface : engine_m_axi_stream_alu_if
`default_nettype wire

// File: rtl/engine_m_axi_stream_alu_lane.sv
`default_nettype none
// ============================================================================
//  Module      : engine_m_axi_stream_alu_lane
//  Description : Combinational single-lane unsigned operation of a lane value
//                against the run constant. Result is truncated to the lane.
//  Ports       : i_mode   - operation select
//                i_a      - lane value from the stream
//                i_const  - latched run constant
//                o_result - lane result
//                o_sat    - clamp happened (only with ENGINE_M_AXI_STREAM_ALU_SAT_EN)
//  Config      : ENGINE_M_AXI_STREAM_ALU_SAT_EN - ADD/SUB clamp instead of wrap
//  Revision    : 1.0 - initial release
// ============================================================================
module engine_m_axi_stream_alu_lane
    import engine_m_axi_stream_alu_pkg::*;
#(
    parameter int C_LANE_WIDTH = 32
) (
    input  alu_mode_t               i_mode,
    input  logic [C_LANE_WIDTH-1:0] i_a,
    input  logic [C_LANE_WIDTH-1:0] i_const,
    output logic [C_LANE_WIDTH-1:0] o_result
`ifdef ENGINE_M_AXI_STREAM_ALU_SAT_EN
    ,
    output logic                    o_sat
`endif
);

`ifdef ENGINE_M_AXI_STREAM_ALU_SAT_EN
    // One extra bit exposes carry-out (ADD) and borrow (SUB).
    logic [C_LANE_WIDTH:0] w_sum;
    logic [C_LANE_WIDTH:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_const};
    assign w_diff = {1'b0, i_a} - {1'b0, i_const};
`endif

    always_comb begin
        o_result = i_a;
`ifdef ENGINE_M_AXI_STREAM_ALU_SAT_EN
        o_sat    = 1'b0;
`endif
        case (i_mode)
`ifdef ENGINE_M_AXI_STREAM_ALU_SAT_EN
            ALU_ADD: begin
                if (w_sum[C_LANE_WIDTH]) begin
                    o_result = '1;
                    o_sat    = 1'b1;
                end else begin
                    o_result = w_sum[C_LANE_WIDTH-1:0];
                end
            end
            ALU_SUB: begin
                if (w_diff[C_LANE_WIDTH]) begin
                    o_result = '0;
                    o_sat    = 1'b1;
                end else begin
                    o_result = w_diff[C_LANE_WIDTH-1:0];
                end
            end
`else
            ALU_ADD: o_result = i_a + i_const;
            ALU_SUB: o_result = i_a - i_const;
`endif
            ALU_AND: o_result = i_a & i_const;
            ALU_OR:  o_result = i_a | i_const;
            ALU_XOR: o_result = i_a ^ i_const;
            ALU_MAX: o_result = (i_a > i_const) ? i_a : i_const;
            ALU_MIN: o_result = (i_a < i_const) ? i_a : i_const;
            default: o_result = i_a;
        endcase
    end

endmodule : engine_m_axi_stream_alu_lane
`default_nettype wire

// File: rtl/engine_m_axi_stream_alu.sv
`default_nettype none
// ============================================================================
//  Module      : engine_m_axi_stream_alu
//  Description : Lane-parallel stream ALU placed between the AXI read and
//                write masters. Each beat is split into lanes, combined with a
//                run constant in the first pipe stage, then delayed through the
//                remaining stages. One global stall keeps the pipe skid-free.
//  Ports       : aclk, areset (async, active-low)
//                ctrl_start/ctrl_mode/ctrl_constant - run start and operands
//                ctrl_done/ctrl_busy/ctrl_beat_count - run status
//                ctrl_sat_flag - sticky clamp flag (SAT build only)
//                s_axis - input stream (slave), m_axis - output stream (master)
//  Config      : ENGINE_M_AXI_STREAM_ALU_SAT_EN - saturating ADD/SUB and
//                the ctrl_sat_flag port
//  Revision    : 1.0 - initial release
// ============================================================================
module engine_m_axi_stream_alu
    import engine_m_axi_stream_alu_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 512,
    parameter int C_LANE_WIDTH       = 32,
    parameter int C_PIPE_STAGES      = 2,
    parameter int C_BEAT_CNT_WIDTH   = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        ctrl_start,
    input  logic [2:0]                  ctrl_mode,
    input  logic [C_LANE_WIDTH-1:0]     ctrl_constant,
    output logic                        ctrl_done,
    output logic                        ctrl_busy,
    output logic [C_BEAT_CNT_WIDTH-1:0] ctrl_beat_count,
`ifdef ENGINE_M_AXI_STREAM_ALU_SAT_EN
    output logic                        ctrl_sat_flag,
`endif
    engine_m_axi_stream_alu_if.slave    s_axis,
    engine_m_axi_stream_alu_if.master   m_axis
);

    localparam int C_LANES  = C_AXIS_TDATA_WIDTH / C_LANE_WIDTH;
    localparam int C_KEEP_W = C_AXIS_TDATA_WIDTH / 8;

    if ((C_AXIS_TDATA_WIDTH % C_LANE_WIDTH) != 0) begin : g_bad_width
        $error("C_AXIS_TDATA_WIDTH must be a multiple of C_LANE_WIDTH");
    end
    if (C_PIPE_STAGES < 1) begin : g_bad_stages
        $error("C_PIPE_STAGES must be at least 1");
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    alu_state_t                  r_state_q, w_state_d;
    alu_mode_t                   r_mode_q,  w_mode_d;
    logic [C_LANE_WIDTH-1:0]     r_const_q, w_const_d;
    logic [C_BEAT_CNT_WIDTH-1:0] r_cnt_q,   w_cnt_d;

    // ------------------------------------------------------------------
    // Pipeline registers; index C_PIPE_STAGES-1 drives m_axis
    // ------------------------------------------------------------------
    logic [C_PIPE_STAGES-1:0]      r_vld_q,  w_vld_d;
    logic [C_AXIS_TDATA_WIDTH-1:0] r_data_q [C_PIPE_STAGES];
    logic [C_AXIS_TDATA_WIDTH-1:0] w_data_d [C_PIPE_STAGES];
    logic [C_KEEP_W-1:0]           r_keep_q [C_PIPE_STAGES];
    logic [C_KEEP_W-1:0]           w_keep_d [C_PIPE_STAGES];
    logic [C_PIPE_STAGES-1:0]      r_last_q, w_last_d;

    logic                          w_pipe_en;
    logic                          w_s_hs;
    logic                          w_m_hs;
    logic                          w_start_acc;
    logic [C_AXIS_TDATA_WIDTH-1:0] w_alu_data;

`ifdef ENGINE_M_AXI_STREAM_ALU_SAT_EN
    logic [C_LANES-1:0] w_lane_sat;
    logic               r_sat_q, w_sat_d;
`endif

    // Whole pipe advances unless the output holds a beat the sink refuses.
    assign w_pipe_en   = !r_vld_q[C_PIPE_STAGES-1] || m_axis.tready;
    assign w_s_hs      = s_axis.tvalid && s_axis.tready;
    assign w_m_hs      = r_vld_q[C_PIPE_STAGES-1] && m_axis.tready;
    assign w_start_acc = ctrl_start && (r_state_q == IDLE);

    // ------------------------------------------------------------------
    // Lane array: operates on the raw input beat, result registered in
    // stage 0.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < C_LANES; g++) begin : g_lane
        engine_m_axi_stream_alu_lane #(
            .C_LANE_WIDTH (C_LANE_WIDTH)
        ) u_lane (
            .i_mode   (r_mode_q),
            .i_a      (s_axis.tdata[g*C_LANE_WIDTH +: C_LANE_WIDTH]),
            .i_const  (r_const_q),
            .o_result (w_alu_data[g*C_LANE_WIDTH +: C_LANE_WIDTH])
`ifdef ENGINE_M_AXI_STREAM_ALU_SAT_EN
            ,
            .o_sat    (w_lane_sat[g])
`endif
        );
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            r_state_q <= IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            IDLE:    if (ctrl_start) w_state_d = RUN;
            RUN:     if (w_s_hs && s_axis.tlast) w_state_d = DRAIN;
            DRAIN:   if (w_m_hs && r_last_q[C_PIPE_STAGES-1]) w_state_d = DONE;
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ctrl_done     = (r_state_q == DONE);
        ctrl_busy     = (r_state_q == RUN) || (r_state_q == DRAIN);
        s_axis.tready = (r_state_q == RUN) && w_pipe_en;
    end

    // ------------------------------------------------------------------
    // Run operands, beat counter, sticky clamp flag
    // ------------------------------------------------------------------
    always_comb begin
        w_mode_d  = r_mode_q;
        w_const_d = r_const_q;
        w_cnt_d   = r_cnt_q;
        if (w_start_acc) begin
            w_mode_d  = alu_mode_t'(ctrl_mode);
            w_const_d = ctrl_constant;
            w_cnt_d   = '0;
        end else if (w_m_hs && (r_cnt_q != '1)) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

`ifdef ENGINE_M_AXI_STREAM_ALU_SAT_EN
    always_comb begin
        w_sat_d = r_sat_q;
        if (w_start_acc) begin
            w_sat_d = 1'b0;
        end else if (w_s_hs && (|w_lane_sat)) begin
            w_sat_d = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            r_sat_q <= 1'b0;
        end else begin
            r_sat_q <= w_sat_d;
        end
    end

    assign ctrl_sat_flag = r_sat_q;
`endif

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            r_mode_q  <= ALU_ADD;
            r_const_q <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_mode_q  <= w_mode_d;
            r_const_q <= w_const_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign ctrl_beat_count = r_cnt_q;

    // ------------------------------------------------------------------
    // Pipeline shift
    // ------------------------------------------------------------------
    always_comb begin
        w_vld_d  = r_vld_q;
        w_data_d = r_data_q;
        w_keep_d = r_keep_q;
        w_last_d = r_last_q;
        if (w_pipe_en) begin
            w_vld_d[0]  = w_s_hs;
            w_data_d[0] = w_alu_data;
            w_keep_d[0] = s_axis.tkeep;
            w_last_d[0] = s_axis.tlast;
            for (int i = 1; i < C_PIPE_STAGES; i++) begin
                w_vld_d[i]  = r_vld_q[i-1];
                w_data_d[i] = r_data_q[i-1];
                w_keep_d[i] = r_keep_q[i-1];
                w_last_d[i] = r_last_q[i-1];
            end
        end
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            r_vld_q  <= '0;
            r_last_q <= '0;
            for (int i = 0; i < C_PIPE_STAGES; i++) begin
                r_data_q[i] <= '0;
                r_keep_q[i] <= '0;
            end
        end else begin
            r_vld_q  <= w_vld_d;
            r_last_q <= w_last_d;
            r_data_q <= w_data_d;
            r_keep_q <= w_keep_d;
        end
    end

    assign m_axis.tvalid = r_vld_q[C_PIPE_STAGES-1];
    assign m_axis.tdata  = r_data_q[C_PIPE_STAGES-1];
    assign m_axis.tkeep  = r_keep_q[C_PIPE_STAGES-1];
    assign m_axis.tlast  = r_last_q[C_PIPE_STAGES-1];

endmodule : engine_m_axi_stream_alu
`default_nettype wire

// File: tb/tb_engine_m_axi_stream_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_engine_m_axi_stream_alu
//  Description : Self-checking bench for engine_m_axi_stream_alu: vector
//                table of per-mode runs, hand sequences for latency, reset
//                abort and ignored start, and a randomized backpressure run
//                against a lane-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_engine_m_axi_stream_alu;

    localparam int DW = 512;
    localparam int LW = 32;
    localparam int NL = DW / LW;
    localparam int KW = DW / 8;
    localparam int PS = 2;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ctrl_start;
    logic [2:0]    ctrl_mode;
    logic [LW-1:0] ctrl_constant;
    logic          ctrl_done;
    logic          ctrl_busy;
    logic [CW-1:0] ctrl_beat_count;
`ifdef ENGINE_M_AXI_STREAM_ALU_SAT_EN
    logic          ctrl_sat_flag;
`endif

    always #5 clk = ~clk;

    engine_m_axi_stream_alu_if #(.DATA_WIDTH(DW)) s_if ();
    engine_m_axi_stream_alu_if #(.DATA_WIDTH(DW)) m_if ();

    engine_m_axi_stream_alu #(
        .C_AXIS_TDATA_WIDTH (DW),
        .C_LANE_WIDTH       (LW),
        .C_PIPE_STAGES      (PS),
        .C_BEAT_CNT_WIDTH   (CW)
    ) dut (
        .aclk            (clk),
        .areset          (rst_n),
        .ctrl_start      (ctrl_start),
        .ctrl_mode       (ctrl_mode),
        .ctrl_constant   (ctrl_constant),
        .ctrl_done       (ctrl_done),
        .ctrl_busy       (ctrl_busy),
        .ctrl_beat_count (ctrl_beat_count),
`ifdef ENGINE_M_AXI_STREAM_ALU_SAT_EN
        .ctrl_sat_flag   (ctrl_sat_flag),
`endif
        .s_axis          (s_if),
        .m_axis          (m_if)
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    beat_t rx_q[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    int    stall_viol = 0;
    int    first_acc_cyc = -1;
    int    first_out_cyc = -1;
    bit    bp_en = 1'b0;
    int    mdl_mode = 0;
    logic [LW-1:0] mdl_const = '0;
    bit    mdl_sat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: plain unsigned arithmetic per lane
    // ------------------------------------------------------------------
    function automatic logic [LW-1:0] ref_lane(input int mode, input longint unsigned a,
                                               input longint unsigned c);
        longint unsigned mod = longint'(1) << LW;
        longint unsigned r;
        case (mode)
`ifdef ENGINE_M_AXI_STREAM_ALU_SAT_EN
            0: r = (a + c >= mod) ? mod - 1 : a + c;
            1: r = (a >= c) ? a - c : 0;
`else
            0: r = (a + c) % mod;
            1: r = (a >= c) ? a - c : a + mod - c;
`endif
            2: r = a & c;
            3: r = a | c;
            4: r = a ^ c;
            5: r = (a > c) ? a : c;
            6: r = (a < c) ? a : c;
            default: r = a;
        endcase
        return LW'(r);
    endfunction

    function automatic bit ref_clamps(input int mode, input logic [DW-1:0] d, input logic [LW-1:0] c);
        bit any = 1'b0;
        for (int l = 0; l < NL; l++) begin
            longint unsigned a = longint'(d[l*LW +: LW]);
            if (mode == 0 && a + longint'(c) >= (longint'(1) << LW)) any = 1'b1;
            if (mode == 1 && a < longint'(c)) any = 1'b1;
        end
        return any;
    endfunction

    function automatic logic [DW-1:0] ref_beat(input int mode, input logic [LW-1:0] c,
                                               input logic [DW-1:0] d);
        logic [DW-1:0] o;
        for (int l = 0; l < NL; l++) o[l*LW +: LW] = ref_lane(mode, longint'(d[l*LW +: LW]), longint'(c));
        return o;
    endfunction

    // ------------------------------------------------------------------
    // Output monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        beat_t e;
        beat_t r;
        if (m_if.tvalid && first_out_cyc < 0) first_out_cyc = cyc;
        if (m_if.tvalid && m_if.tready) begin
            r.d = m_if.tdata; r.k = m_if.tkeep; r.l = m_if.tlast;
            rx_q.push_back(r);
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL sb_unexpected: got beat %0h expected no beat", m_if.tdata);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", r.d, e.d);
                check("sb_keep_last", DW'({r.k, r.l}), DW'({e.k, e.l}));
            end
        end
        if (ctrl_done) done_cnt++;
        if (m_if.tvalid && !m_if.tready && s_if.tready) stall_viol++;
    end

    // Sink ready: always 1 unless backpressure is enabled
    initial begin
        m_if.tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_if.tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------
    task automatic start_run(input int mode, input logic [LW-1:0] c);
        rx_q.delete();
        first_acc_cyc = -1;
        first_out_cyc = -1;
        mdl_mode  = mode;
        mdl_const = c;
        mdl_sat   = 1'b0;
        ctrl_start = 1'b1; ctrl_mode = 3'(mode); ctrl_constant = c;
        @(posedge clk); #1;
        ctrl_start = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        beat_t b;
        bit    ok = 1'b0;
        s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tkeep = k; s_if.tlast = l;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (s_if.tready) begin ok = 1'b1; break; end
        end
        if (ok) begin
            b.d = ref_beat(mdl_mode, mdl_const, d); b.k = k; b.l = l;
            exp_q.push_back(b);
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            if (ref_clamps(mdl_mode, d, mdl_const)) mdl_sat = 1'b1;
        end else begin
            tests++; fails++;
            $display("FAIL send_timeout: got tready 0 required 1");
        end
        @(posedge clk); #1;
        s_if.tvalid = 1'b0; s_if.tlast = 1'b0;
    endtask

    task automatic wait_done(input int exp_count);
        bit seen = 1'b0;
        int d0 = done_cnt;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (ctrl_done) begin seen = 1'b1; break; end
        end
        check("done_seen", DW'(seen), DW'(1));
        @(posedge clk); #1;
        check("done_once", DW'(done_cnt - d0), DW'(1));
        check("beat_count", DW'(ctrl_beat_count), DW'(exp_count));
        check("rx_count", DW'(rx_q.size()), DW'(exp_count));
`ifdef ENGINE_M_AXI_STREAM_ALU_SAT_EN
        check("sat_flag", DW'(ctrl_sat_flag), DW'(mdl_sat));
`endif
    endtask

    function automatic logic [DW-1:0] pat(input logic [LW-1:0] a, input logic [LW-1:0] b);
        logic [DW-1:0] d;
        for (int l = 0; l < NL; l++) d[l*LW +: LW] = (l % 2 == 0) ? a : b;
        return d;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int l = 0; l < NL; l++) d[l*LW +: LW] = $urandom;
        return d;
    endfunction

    // ------------------------------------------------------------------
    // Vector table: even lanes = a, odd lanes = b
    // ------------------------------------------------------------------
    typedef struct {
        int            mode;
        logic [LW-1:0] c;
        logic [LW-1:0] a;
        logic [LW-1:0] b;
        logic [KW-1:0] keep;
        logic [LW-1:0] ea;
        logic [LW-1:0] eb;
    } vec_t;

    vec_t vt[8];

    initial begin
        automatic logic [KW-1:0] all_keep = '1;
        int d_before;

        vt[0] = '{0, 32'd5, 32'hFFFF_FFFE, 32'h0000_0010, all_keep, 32'h0000_0003, 32'h0000_0015};
        vt[1] = '{1, 32'd10, 32'd3, 32'd20, all_keep, 32'hFFFF_FFF9, 32'd10};
`ifdef ENGINE_M_AXI_STREAM_ALU_SAT_EN
        vt[0].ea = 32'hFFFF_FFFF;
        vt[1].ea = 32'd0;
`endif
        vt[2] = '{5, 32'd100, 32'd50, 32'd150, {16{4'h0, 4'hF}}, 32'd100, 32'd150};
        vt[3] = '{6, 32'd100, 32'd50, 32'd150, 64'h0000_FFFF_0000_FFFF, 32'd50, 32'd100};
        vt[4] = '{2, 32'hF0F0_F0F0, 32'h1234_5678, 32'hFFFF_FFFF, 64'h1, 32'h1030_5070, 32'hF0F0_F0F0};
        vt[5] = '{3, 32'h0000_FFFF, 32'h1234_0000, 32'h0, all_keep, 32'h1234_FFFF, 32'h0000_FFFF};
        vt[6] = '{4, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h0, 64'h8000_0000_0000_0000, 32'hF0F0_F0F0, 32'hFFFF_FFFF};
        vt[7] = '{7, 32'd7, 32'hDEAD_BEEF, 32'd1, all_keep, 32'hDEAD_BEEF, 32'd1};

        ctrl_start = 1'b0; ctrl_mode = '0; ctrl_constant = '0;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", DW'(ctrl_busy), DW'(0));
        check("rst_done", DW'(ctrl_done), DW'(0));
        check("rst_count", DW'(ctrl_beat_count), DW'(0));
        check("rst_s_tready", DW'(s_if.tready), DW'(0));
        check("rst_m_tvalid", DW'(m_if.tvalid), DW'(0));
        check("rst_m_tlast", DW'(m_if.tlast), DW'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ADD 5, 4 beats of 0xFFFFFFFE, latency check
        start_run(0, 32'd5);
        check("busy_run", DW'(ctrl_busy), DW'(1));
        for (int i = 0; i < 4; i++) send_beat(pat(32'hFFFF_FFFE, 32'hFFFF_FFFE), '1, i == 3);
        wait_done(4);
        check("latency", DW'(first_out_cyc - first_acc_cyc), DW'(PS));
`ifdef ENGINE_M_AXI_STREAM_ALU_SAT_EN
        check("add_lane", DW'(rx_q[0].d[LW-1:0]), DW'(32'hFFFF_FFFF));
`else
        check("add_lane", DW'(rx_q[0].d[LW-1:0]), DW'(32'h0000_0003));
`endif
        check("idle_busy", DW'(ctrl_busy), DW'(0));

        // Table-driven per-mode runs, 2 beats each
        for (int v = 0; v < 8; v++) begin
            start_run(vt[v].mode, vt[v].c);
            send_beat(pat(vt[v].a, vt[v].b), vt[v].keep, 1'b0);
            send_beat(pat(vt[v].b, vt[v].a), vt[v].keep, 1'b1);
            wait_done(2);
            if (rx_q.size() == 2) begin
                check("vec_lane_a", DW'(rx_q[0].d[LW-1:0]), DW'(vt[v].ea));
                check("vec_lane_b", DW'(rx_q[0].d[2*LW-1:LW]), DW'(vt[v].eb));
                check("vec_swap_a", DW'(rx_q[1].d[LW-1:0]), DW'(vt[v].eb));
                check("vec_keep", DW'(rx_q[1].k), DW'(vt[v].keep));
            end
        end

        // Randomized backpressure run, 64 beats
        bp_en = 1'b1;
        start_run(int'($urandom_range(0, 7)), $urandom);
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
            send_beat(rnd_data(), KW'({$urandom, $urandom}), i == 63);
        end
        wait_done(64);
        bp_en = 1'b0;
        check("stall_tready", DW'(stall_viol), DW'(0));

        // Reset after 3 of 8 beats: in-flight beats dropped, no done
        start_run(0, 32'd1);
        for (int i = 0; i < 3; i++) send_beat(rnd_data(), '1, 1'b0);
        d_before = done_cnt;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("abort_tvalid", DW'(m_if.tvalid), DW'(0));
        check("abort_count", DW'(ctrl_beat_count), DW'(0));
        check("abort_busy", DW'(ctrl_busy), DW'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", DW'(done_cnt - d_before), DW'(0));
        check("abort_tready", DW'(s_if.tready), DW'(0));
        start_run(3, 32'h0000_00FF);
        send_beat(rnd_data(), '1, 1'b0);
        send_beat(rnd_data(), '1, 1'b1);
        wait_done(2);

        // Start pulse during RUN (XOR) must be ignored: ADD persists
        start_run(0, 32'd7);
        send_beat(rnd_data(), '1, 1'b0);
        ctrl_start = 1'b1; ctrl_mode = 3'd4; ctrl_constant = 32'hFFFF_FFFF;
        send_beat(pat(32'd1, 32'd2), '1, 1'b0);
        ctrl_start = 1'b0;
        send_beat(rnd_data(), '1, 1'b0);
        send_beat(rnd_data(), '1, 1'b1);
        wait_done(4);
        if (rx_q.size() == 4) check("ign_start_lane", DW'(rx_q[1].d[2*LW-1:0]), DW'({32'd9, 32'd8}));

        check("sb_empty", DW'(exp_q.size()), DW'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_engine_m_axi_stream_alu
`default_nettype wire

// File: doc/engine_m_axi_stream_alu.md
Name: engine_m_axi_stream_alu

Overview:
- Parametrised successor to the fixed single-constant adder stage between the AXI read master and the AXI write master of an engine.
- Splits each AXI4-Stream beat into C_AXIS_TDATA_WIDTH/C_LANE_WIDTH lanes and applies a run-time-selected op against a latched constant.
- Pipelined with full backpressure; counts beats and signals completion on tlast.
- Drop-in between engine_m_axi_read and engine_m_axi_write.

Parameters:
- C_AXIS_TDATA_WIDTH, 512, stream data width in bits; must be a multiple of C_LANE_WIDTH (elaboration $error otherwise).
- C_LANE_WIDTH, 32, lane width in bits (8/16/32/64).
- C_PIPE_STAGES, 2, register stages from input to output (>=1).
- C_BEAT_CNT_WIDTH, 32, width of the beat counter.

Ports:
- aclk  in  1  single clock.
- areset  in  1  asynchronous reset, active-low.
- ctrl_start  in  1  one-cycle start pulse; honoured only in IDLE.
- ctrl_mode  in  3  op select; latched on accepted start.
- ctrl_constant  in  C_LANE_WIDTH  lane operand; latched on accepted start.
- ctrl_done  out  1  one-cycle pulse when the run completes.
- ctrl_busy  out  1  high in RUN/DRAIN.
- ctrl_beat_count  out  C_BEAT_CNT_WIDTH  beats emitted this run; held until next start.
- s_axis_tvalid/tready  in/out  1  input handshake.
- s_axis_tdata  in  C_AXIS_TDATA_WIDTH  input data.
- s_axis_tkeep  in  C_AXIS_TDATA_WIDTH/8  byte keep, forwarded unchanged.
- s_axis_tlast  in  1  end of run.
- m_axis_tvalid/tready  out/in  1  output handshake.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  result.
- m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  delayed tkeep.
- m_axis_tlast  out  1  delayed tlast.

Behaviour:
- Reset (areset=0, async assert, sync release): FSM=IDLE, all pipe valids 0, ctrl_done=0, ctrl_busy=0, ctrl_beat_count=0, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, data/keep regs 0. Reset mid-run discards all in-flight beats; no ctrl_done is produced.
- FSM IDLE -> RUN on ctrl_start: latch mode and constant, clear the beat count.
- RUN -> DRAIN when a beat with s_axis_tlast=1 is accepted.
- DRAIN -> DONE when the tlast beat completes its m_axis handshake.
- DONE -> IDLE unconditionally after one cycle; ctrl_done=1 in that cycle only.
- ctrl_start outside IDLE is ignored.
- Pipeline: stage enable pipe_en = !m_axis_tvalid || m_axis_tready (global stall).
- s_axis_tready = (state==RUN) && pipe_en, so no skid buffer is required.
- Latency is exactly C_PIPE_STAGES cycles from s-handshake to m_axis_tvalid when there is no backpressure. Throughput is 1 beat/cycle.
- Modes, per lane, unsigned, result truncated to C_LANE_WIDTH:
  - 0 ADD (wraps mod 2^W), 1 SUB (wraps), 2 AND, 3 OR, 4 XOR, 5 MAX, 6 MIN, 7 PASS.
  - Op is computed in stage 1; later stages are pure delay.
- Lanes are computed irrespective of tkeep; tkeep and tlast travel alongside the data.
- ctrl_beat_count increments on each m-handshake and saturates at all-ones.
- Simultaneous s- and m-handshakes in one cycle are legal; occupancy is unchanged.
- Beats presented in IDLE/DRAIN/DONE are not accepted (tready=0).

Optional Feature:
- Macro: ENGINE_M_AXI_STREAM_ALU_SAT_EN.
- Defined: ADD clamps to 2^W-1 on carry-out; SUB clamps to 0 on borrow. Adds output ctrl_sat_flag (1 bit), sticky per run: set on any clamp, cleared on accepted start, reset 0.
- Undefined: ADD/SUB wrap; no ctrl_sat_flag port.

Decomposition:
- Shared package (global_package): typedef enum logic[2:0] alu_mode_t {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_MAX, ALU_MIN, ALU_PASS}; typedef enum for FSM states {IDLE, RUN, DRAIN, DONE}.
- Sub-module engine_m_axi_stream_alu_lane: combinational single-lane op (mode, a, const -> result, sat). Instantiated C_AXIS_TDATA_WIDTH/C_LANE_WIDTH times by generate.

Test Plan:
- Defaults, mode ADD, const 5, 4 beats with all lanes = 0xFFFFFFFE, tlast on beat 4, m_tready=1 -> lanes 0x00000003; first output 2 cycles after first accept; ctrl_done pulses once; ctrl_beat_count=4.
- Mode SUB, const 10, lane values 3 and 20 -> 0xFFFFFFF9 and 10. With SAT_EN: 0 and 10, ctrl_sat_flag=1.
- Mode MAX, const 100; then MIN, const 100; lanes {50,150} -> {100,150} and {50,100}. tkeep=0x0000FFFF... passes through unchanged.
- Backpressure: m_tready toggles 1-0-0-1 randomly over 64 beats -> no beat lost or duplicated, order preserved, s_tready never high while the pipe is stalled and full.
- Areset low for 1 cycle after 3 of 8 beats -> all outputs at reset values, no ctrl_done. A new start with 2 beats then completes with count=2.
- ctrl_start pulsed during RUN with mode XOR -> ignored; original ADD mode result persists on all beats.
